// File: rtl/mips32_run_ctrl.sv
// mips32 run/load sequencer: imem programming, core reset/start,
// branch-flush bubbles, halt drain, watchdog and cycle counting.
module mips32_run_ctrl #(
   parameter int IMEM_DEPTH   = 1024,
   parameter int ADDR_W       = 10,
   parameter int DRAIN_CYCLES = 4,
   parameter int FLUSH_CYCLES = 2,
   parameter int MAX_CYCLES   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_req,
   input  logic              start,
   input  logic              prog_valid,
   input  logic [31:0]       prog_data,
   input  logic              prog_last,
   output logic              prog_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   input  logic              hlt,
   input  logic              br_taken,
   output logic              core_en,
   output logic              core_rst,
   output logic              flush,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   load_words,
   output logic [31:0]       cycle_count
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int FW = $clog2(FLUSH_CYCLES + 1);
   localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);
   localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES);
   localparam logic [ADDR_W:0] LAST_W = (ADDR_W + 1)'(IMEM_DEPTH - 1);
   localparam logic [ADDR_W:0] FULL_W = (ADDR_W + 1)'(IMEM_DEPTH);
   localparam logic WD_EN = (MAX_CYCLES != 0);
   localparam logic [31:0] WD_LIM = 32'(MAX_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_HALTED
   } state_t;

   state_t state_q, state_d;
   logic [ADDR_W:0] wcnt_q, wcnt_d;
   logic [ADDR_W:0] lwords_q, lwords_d;
   logic [31:0] cyc_q, cyc_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic err_q, err_d;

   logic accept;
   logic wd_hit;
   logic [31:0] cyc_inc;

   assign accept  = (state_q == S_LOAD) & prog_valid;
   assign wd_hit  = WD_EN & (cyc_q == WD_LIM);
   assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + 32'd1;

   // Outputs decoded from state; imem write port follows the accept.
   assign prog_ready  = (state_q == S_LOAD);
   assign imem_we     = accept;
   assign imem_addr   = accept ? wcnt_q[ADDR_W-1:0] : '0;
   assign imem_wdata  = accept ? prog_data : '0;
   assign core_en     = (state_q == S_RUN) | (state_q == S_DRAIN);
   assign core_rst    = (state_q == S_CLEAR);
   assign flush       = (state_q == S_DRAIN) |
                        ((state_q == S_RUN) & (fcnt_q != '0));
   assign busy        = (state_q == S_LOAD) | (state_q == S_CLEAR) |
                        (state_q == S_RUN) | (state_q == S_DRAIN);
   assign done        = (state_q == S_HALTED);
   assign err         = err_q;
   assign load_words  = lwords_q;
   assign cycle_count = cyc_q;

   // Next-state and counter updates.
   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      lwords_d = lwords_q;
      cyc_d    = cyc_q;
      fcnt_d   = fcnt_q;
      dcnt_d   = dcnt_q;
      err_d    = err_q;
      unique case (state_q)
         S_IDLE, S_HALTED: begin
            if (load_req) begin
               state_d = S_LOAD;
               wcnt_d  = '0;
               err_d   = 1'b0;
            end else if (start) begin
               state_d = S_CLEAR;
               err_d   = 1'b0;
            end
         end
         S_LOAD: begin
            if (accept) begin
               wcnt_d = wcnt_q + 1'b1;
               if (prog_last) begin
                  lwords_d = wcnt_q + 1'b1;
                  state_d  = S_IDLE;
               end else if (wcnt_q == LAST_W) begin
                  lwords_d = FULL_W;
                  err_d    = 1'b1;
                  state_d  = S_IDLE;
               end
            end
         end
         S_CLEAR: begin
            cyc_d   = '0;
            fcnt_d  = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            cyc_d = cyc_inc;
            if (fcnt_q != '0) fcnt_d = fcnt_q - 1'b1;
            if (wd_hit) begin
               err_d   = 1'b1;
               state_d = S_HALTED;
            end else if (hlt) begin
               dcnt_d  = DRAIN_INIT;
               state_d = S_DRAIN;
            end else if (br_taken) begin
               fcnt_d = FLUSH_INIT;
            end
         end
         S_DRAIN: begin
            cyc_d = cyc_inc;
            if (wd_hit) begin
               err_d   = 1'b1;
               state_d = S_HALTED;
            end else if (dcnt_q == '0) begin
               state_d = S_HALTED;
            end else begin
               dcnt_d = dcnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         wcnt_q   <= '0;
         lwords_q <= '0;
         cyc_q    <= '0;
         fcnt_q   <= '0;
         dcnt_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         lwords_q <= lwords_d;
         cyc_q    <= cyc_d;
         fcnt_q   <= fcnt_d;
         dcnt_q   <= dcnt_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_mips32_run_ctrl.sv
// Scoreboard bench for mips32_run_ctrl: two instances (watchdog off
// and MAX_CYCLES=8) checked against a time-based reference model.
module tb_mips32_run_ctrl;

   localparam int DEPTH = 1024;
   localparam int DRAIN = 4;
   localparam int FLUSH = 2;
   localparam int P_IDLE = 0, P_LOAD = 1, P_CLEAR = 2;
   localparam int P_RUN = 3, P_DRAIN = 4, P_HALT = 5;

   typedef struct packed {
      logic        prog_ready;
      logic        we;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic        core_en;
      logic        core_rst;
      logic        flush;
      logic        busy;
      logic        done;
      logic        err;
      logic [10:0] lw;
      logic [31:0] cyc;
   } exp_t;

   typedef struct {
      int     ph;
      int     wc;
      int     lw;
      longint cyc;
      longint fl_until;
      longint halt_at;
      bit     err;
   } mdl_t;

   logic clk = 0;
   logic rst = 1;
   logic load_req = 0, start = 0, prog_valid = 0, prog_last = 0;
   logic [31:0] prog_data = '0;
   logic hlt = 0, br_taken = 0;

   logic        pr0, we0, ce0, cr0, fl0, bu0, dn0, er0;
   logic [9:0]  ad0;
   logic [31:0] wd0, cc0;
   logic [10:0] lw0;
   logic        pr1, we1, ce1, cr1, fl1, bu1, dn1, er1;
   logic [9:0]  ad1;
   logic [31:0] wd1, cc1;
   logic [10:0] lw1;

   exp_t act0, act1;
   exp_t q0[$];
   exp_t q1[$];
   mdl_t m0, m1;
   longint tick = 0;
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mips32_run_ctrl u_dut0 (
      .clk(clk), .rst(rst), .load_req(load_req), .start(start),
      .prog_valid(prog_valid), .prog_data(prog_data),
      .prog_last(prog_last), .prog_ready(pr0), .imem_we(we0),
      .imem_addr(ad0), .imem_wdata(wd0), .hlt(hlt),
      .br_taken(br_taken), .core_en(ce0), .core_rst(cr0),
      .flush(fl0), .busy(bu0), .done(dn0), .err(er0),
      .load_words(lw0), .cycle_count(cc0)
   );

   mips32_run_ctrl #(.MAX_CYCLES(8)) u_dut1 (
      .clk(clk), .rst(rst), .load_req(load_req), .start(start),
      .prog_valid(prog_valid), .prog_data(prog_data),
      .prog_last(prog_last), .prog_ready(pr1), .imem_we(we1),
      .imem_addr(ad1), .imem_wdata(wd1), .hlt(hlt),
      .br_taken(br_taken), .core_en(ce1), .core_rst(cr1),
      .flush(fl1), .busy(bu1), .done(dn1), .err(er1),
      .load_words(lw1), .cycle_count(cc1)
   );

   assign act0 = {pr0, we0, ad0, wd0, ce0, cr0, fl0, bu0, dn0, er0, lw0, cc0};
   assign act1 = {pr1, we1, ad1, wd1, ce1, cr1, fl1, bu1, dn1, er1, lw1, cc1};

   function automatic mdl_t reset_model();
      mdl_t n;
      n.ph = P_IDLE; n.wc = 0; n.lw = 0; n.cyc = 0;
      n.fl_until = 0; n.halt_at = 0; n.err = 0;
      return n;
   endfunction

   function automatic exp_t expect_out(mdl_t m, longint t);
      exp_t e;
      bit acc;
      e = '0;
      acc = (m.ph == P_LOAD) && prog_valid;
      e.prog_ready = (m.ph == P_LOAD);
      e.we = acc;
      e.addr = acc ? 10'(m.wc) : 10'd0;
      e.wdata = acc ? prog_data : 32'd0;
      e.core_en = (m.ph == P_RUN) || (m.ph == P_DRAIN);
      e.core_rst = (m.ph == P_CLEAR);
      e.flush = (m.ph == P_DRAIN) || (m.ph == P_RUN && t < m.fl_until);
      e.busy = (m.ph >= P_LOAD) && (m.ph <= P_DRAIN);
      e.done = (m.ph == P_HALT);
      e.err = m.err;
      e.lw = 11'(m.lw);
      e.cyc = 32'(m.cyc);
      return e;
   endfunction

   function automatic mdl_t advance(mdl_t m, longint t, int maxc);
      mdl_t n;
      bit wd;
      if (rst) return reset_model();
      n = m;
      wd = (maxc != 0) && (m.cyc == maxc - 1);
      case (m.ph)
         P_IDLE, P_HALT: begin
            if (load_req) begin
               n.ph = P_LOAD; n.wc = 0; n.err = 0;
            end else if (start) begin
               n.ph = P_CLEAR; n.err = 0;
            end
         end
         P_LOAD: begin
            if (prog_valid) begin
               n.wc = m.wc + 1;
               if (prog_last) begin
                  n.lw = m.wc + 1; n.ph = P_IDLE;
               end else if (m.wc == DEPTH - 1) begin
                  n.lw = DEPTH; n.err = 1; n.ph = P_IDLE;
               end
            end
         end
         P_CLEAR: begin
            n.cyc = 0; n.fl_until = 0; n.ph = P_RUN;
         end
         P_RUN, P_DRAIN: begin
            n.cyc = (m.cyc >= 64'hFFFF_FFFF) ? m.cyc : m.cyc + 1;
            if (wd) begin
               n.err = 1; n.ph = P_HALT;
            end else if (m.ph == P_DRAIN) begin
               if (t + 1 == m.halt_at) n.ph = P_HALT;
            end else if (hlt) begin
               n.ph = P_DRAIN; n.halt_at = t + 1 + DRAIN;
            end else if (br_taken) begin
               n.fl_until = t + 1 + FLUSH;
            end
         end
         default: n = reset_model();
      endcase
      return n;
   endfunction

   // Issue one cycle: queue expectations, advance models, then clock.
   task automatic step();
      q0.push_back(expect_out(m0, tick));
      q1.push_back(expect_out(m1, tick));
      m0 = advance(m0, tick, 0);
      m1 = advance(m1, tick, 8);
      tick++;
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      rst = 0; load_req = 0; start = 0; prog_valid = 0;
      prog_last = 0; prog_data = '0; hlt = 0; br_taken = 0;
   endtask

   task automatic idle(input int n);
      clr_in();
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_start();
      clr_in(); start = 1; step();
      clr_in(); step();
   endtask

   // Monitor: compare every cycle the DUTs present outputs.
   always @(negedge clk) begin
      exp_t e;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         vectors++;
         if (act0 !== e) begin
            miscompares++;
            $display("FAIL outs_dut0 t=%0t got %h want %h", $time, act0, e);
         end
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         vectors++;
         if (act1 !== e) begin
            miscompares++;
            $display("FAIL outs_dut1 t=%0t got %h want %h", $time, act1, e);
         end
      end
   end

   initial begin
      logic [31:0] prog3 [3];
      prog3[0] = 32'h0022_1800;
      prog3[1] = 32'h0441_0005;
      prog3[2] = 32'hFC00_0000;
      m0 = reset_model();
      m1 = reset_model();
      @(posedge clk);
      #1;
      rst = 1; step();
      idle(2);

      // Three-word program
      load_req = 1; step();
      for (int i = 0; i < 3; i++) begin
         clr_in(); prog_valid = 1; prog_data = prog3[i];
         prog_last = (i == 2); step();
      end
      idle(3);

      // Overflow load, with occasional valid gaps
      load_req = 1; step();
      for (int i = 0; i < DEPTH; i++) begin
         clr_in();
         if ($urandom_range(0, 7) == 0) step();
         prog_valid = 1; prog_data = $urandom; step();
      end
      idle(3);

      // Run with hlt in the 10th RUN cycle
      do_start();
      for (int i = 1; i <= 10; i++) begin
         clr_in(); hlt = (i == 10); step();
      end
      idle(8);

      // Branch flush reload, then hlt together with br_taken
      do_start();
      for (int i = 1; i <= 10; i++) begin
         clr_in();
         br_taken = (i == 5) || (i == 6) || (i == 10);
         hlt = (i == 10);
         step();
      end
      idle(8);

      // Reset in the middle of RUN
      do_start();
      idle(3);
      rst = 1; step();
      idle(2);

      // Reset in the middle of LOAD, on word 2
      load_req = 1; step();
      for (int i = 0; i < 2; i++) begin
         clr_in(); prog_valid = 1; prog_data = $urandom; step();
      end
      clr_in(); rst = 1; prog_valid = 1; prog_data = $urandom; step();
      idle(2);

      // load_req and start together from IDLE
      load_req = 1; start = 1; step();
      clr_in(); prog_valid = 1; prog_data = $urandom; prog_last = 1; step();
      idle(2);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         rst        = ($urandom_range(0, 999) < 4);
         load_req   = ($urandom_range(0, 999) < 20);
         start      = ($urandom_range(0, 999) < 30);
         prog_valid = ($urandom_range(0, 99) < 60);
         prog_last  = ($urandom_range(0, 99) < 5);
         prog_data  = $urandom;
         hlt        = ($urandom_range(0, 99) < 4);
         br_taken   = ($urandom_range(0, 99) < 15);
         step();
      end
      idle(4);

      @(posedge clk);
      @(posedge clk);
      if (q0.size() != 0 || q1.size() != 0) begin
         miscompares++;
         $display("FAIL drain_queues got %0d/%0d pending want 0/0",
                  q0.size(), q1.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
